// File: rtl/hamming15_decode_seq.sv
// Two-stage pipelined Hamming(15,11) SEC decoder with valid/ready flow control
// and a saturating count of corrected words.
module hamming15_decode_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:1]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:1]      out_data,
  output logic             out_err,
  output logic [3:0]       out_synd,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // XOR of the positions of all set bits equals the per-bit parity syndrome.
  function automatic logic [3:0] calc_synd(input logic [15:1] code);
    logic [3:0] s;
    s = 4'd0;
    for (int p = 1; p <= 15; p++) begin
      if (code[p]) s = s ^ p[3:0];
    end
    return s;
  endfunction

  function automatic logic [15:1] onehot_flip(input logic [3:0] synd);
    logic [15:1] f;
    f = 15'h0000;
    if (synd != 4'd0) f[synd] = 1'b1;
    return f;
  endfunction

  function automatic logic [11:1] extract_data(input logic [15:1] c);
    return {c[15], c[14], c[13], c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [15:1]      s1_code_q, s1_code_d;
  logic [3:0]       s1_synd_q, s1_synd_d;
  logic             s2_valid_q, s2_valid_d;
  logic [11:1]      out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [3:0]       out_synd_q, out_synd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_adv_s, s2_adv_s;
  logic [15:1]      corrected_s;

  // Handshake, stage advance and counter next-state logic.
  always_comb begin
    s2_adv_s    = ~s2_valid_q | out_ready;
    s1_adv_s    = ~s1_valid_q | s2_adv_s;
    corrected_s = s1_code_q ^ onehot_flip(s1_synd_q);
    s1_valid_d  = s1_valid_q;
    s1_code_d   = s1_code_q;
    s1_synd_d   = s1_synd_q;
    s2_valid_d  = s2_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_synd_d  = out_synd_q;
    cnt_d       = cnt_q;

    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_synd_d = calc_synd(in_code);
      end else begin
        s1_code_d = s1_code_q;
        s1_synd_d = s1_synd_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Output registers only change when a word moves into stage 2.
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = extract_data(corrected_s);
        out_err_d  = (s1_synd_q != 4'd0);
        out_synd_d = s1_synd_q;
      end else begin
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        out_synd_d = out_synd_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (clr_count) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (s2_valid_q && out_ready && out_err_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= 15'h0000;
      s1_synd_q  <= 4'd0;
      s2_valid_q <= 1'b0;
      out_data_q <= 11'h000;
      out_err_q  <= 1'b0;
      out_synd_q <= 4'd0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_synd_q  <= s1_synd_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      out_synd_q <= out_synd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_synd  = out_synd_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_hamming15_decode_seq.sv
// Directed self-checking bench for hamming15_decode_seq with a 2-bit counter.
`timescale 1ns/1ps
module tb_hamming15_decode_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:1] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [11:1] out_data;
  logic        out_err;
  logic [3:0]  out_synd;
  logic        clr_count;
  logic [1:0]  err_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  hamming15_decode_seq #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_synd  (out_synd),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_exp();
    if (exp_cnt < 3) exp_cnt++;
  endtask

  // Present one word with out_ready high, check it two edges later, then let it transfer.
  task automatic send_one(input string tag, input logic [15:1] code, input logic [11:1] ed,
                          input logic [3:0] es, input logic ee);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_code  = 15'h5A5A;
    chk({tag, " out_valid_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_data"}, 32'(out_data), 32'(ed));
    chk({tag, " out_synd"}, 32'(out_synd), 32'(es));
    chk({tag, " out_err"}, 32'(out_err), 32'(ee));
    chk({tag, " cnt_before"}, 32'(err_count), 32'(exp_cnt));
    step();
    if (ee) bump_exp();
    chk({tag, " cnt_after"}, 32'(err_count), 32'(exp_cnt));
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 15'h0000;
    out_ready = 1'b0;
    clr_count = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_err", 32'(out_err), 32'd0);
    chk("rst out_synd", 32'(out_synd), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    step();

    send_one("zero", 15'h0000, 11'h000, 4'd0, 1'b0);
    send_one("ones", 15'h7FFF, 11'h7FF, 4'd0, 1'b0);
    send_one("valid_d1", 15'h0007, 11'h001, 4'd0, 1'b0);
    // Five erroneous words saturate the 2-bit counter at 3.
    send_one("pos5", 15'h0010, 11'h000, 4'd5, 1'b1);
    send_one("pos1", 15'h7FFE, 11'h7FF, 4'd1, 1'b1);
    send_one("pos15", 15'h4000, 11'h000, 4'd15, 1'b1);
    send_one("pos3", 15'h7FFB, 11'h7FF, 4'd3, 1'b1);
    send_one("double", 15'h0003, 11'h001, 4'd3, 1'b1);
    chk("saturated", 32'(err_count), 32'd3);

    // Clear coinciding with an erroneous transfer must win.
    in_valid  = 1'b1;
    in_code   = 15'h0010;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("clr out_err", 32'(out_err), 32'd1);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    exp_cnt   = 0;
    chk("clr wins", 32'(err_count), 32'd0);
    send_one("after_clr", 15'h0100, 11'h000, 4'd9, 1'b1);

    // Backpressure: A, B, C back to back with the output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 15'h0000;
    #1;
    chk("bp A in_ready", 32'(in_ready), 32'd1);
    step();
    in_code = 15'h7FFF;
    chk("bp B in_ready", 32'(in_ready), 32'd1);
    step();
    in_code = 15'h0010;
    chk("bp full in_ready", 32'(in_ready), 32'd0);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp out_data", 32'(out_data), 32'h000);
    step();
    chk("bp hold in_ready", 32'(in_ready), 32'd0);
    chk("bp hold data", 32'(out_data), 32'h000);
    chk("bp hold synd", 32'(out_synd), 32'd0);
    step();
    chk("bp hold2 data", 32'(out_data), 32'h000);
    chk("bp hold2 valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp B valid", 32'(out_valid), 32'd1);
    chk("bp B data", 32'(out_data), 32'h7FF);
    step();
    chk("bp C valid", 32'(out_valid), 32'd1);
    chk("bp C data", 32'(out_data), 32'h000);
    chk("bp C synd", 32'(out_synd), 32'd5);
    chk("bp C err", 32'(out_err), 32'd1);
    step();
    bump_exp();
    chk("bp drained", 32'(out_valid), 32'd0);
    chk("bp count", 32'(err_count), 32'(exp_cnt));

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 15'h0010;
    step();
    in_code = 15'h7FFF;
    step();
    in_valid = 1'b0;
    chk("pre_rst full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst in_ready", 32'(in_ready), 32'd1);
    chk("arst err_count", 32'(err_count), 32'd0);
    chk("arst out_data", 32'(out_data), 32'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no stale word", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
